// File: rtl/inst_prefetch_queue.sv
//==============================================================================
// Module   : inst_prefetch_queue
// Brief    : Sequential instruction prefetcher feeding decode through a
//            DEPTH-entry {PC, inst} FIFO; flushes on a taken-branch redirect.
//            Optional macro PREFETCH_STATS_EN adds fetch/flush counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        HTRANS,
    output logic [63:0] HADDR,
    input  logic        HREADY,
    input  logic [63:0] HRDATA,
    input  logic        take_branch,
    input  logic [63:0] branch_PC,
    input  logic [63:0] take_branch_offset,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] PC
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_DATA   = 2'd2,
        S_SQUASH = 2'd3
    } state_t;

    state_t               r_state;
    logic [63:0]          r_fetch_pc;
    logic [63:0]          r_data_addr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [63:0]          r_pc_mem   [DEPTH];
    logic [31:0]          r_inst_mem [DEPTH];

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [63:0]          w_target;
    logic [31:0]          w_fetched_inst;

    assign w_empty        = (r_count == '0);
    assign w_full         = (r_count == c_CNT_W'(DEPTH));
    assign w_push         = (r_state == S_DATA) && HREADY;
    assign w_pop          = !w_empty && !stall;
    assign w_target       = (branch_PC + take_branch_offset) & ~64'h3;
    assign w_fetched_inst = r_data_addr[2] ? HRDATA[63:32] : HRDATA[31:0];

    assign HTRANS     = (r_state == S_REQ);
    assign HADDR      = r_fetch_pc;
    assign inst_valid = !w_empty;
    assign inst       = w_empty ? NOP_INST : r_inst_mem[r_rd_ptr];
    assign PC         = w_empty ? 64'h0    : r_pc_mem[r_rd_ptr];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_data_addr <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else if (take_branch) begin
            // Redirect wins over any push/pop this cycle; an in-flight data
            // phase still has to drain, hence SQUASH rather than IDLE.
            r_fetch_pc <= w_target;
            r_rd_ptr   <= r_wr_ptr;
            r_count    <= '0;
            r_state    <= ((r_state == S_DATA) || (r_state == S_SQUASH)) ? S_SQUASH : S_IDLE;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            case (r_state)
                S_IDLE: begin
                    if (!w_full) r_state <= S_REQ;
                end
                S_REQ: begin
                    if (HREADY) begin
                        r_data_addr <= r_fetch_pc;
                        r_fetch_pc  <= r_fetch_pc + 64'd4;
                        r_state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    // Only one fetch is ever outstanding, so a slot is free
                    // after this push unless it fills the last one unpopped.
                    if (HREADY)
                        r_state <= (w_pop || (r_count != c_CNT_W'(DEPTH - 1))) ? S_REQ : S_IDLE;
                end
                S_SQUASH: begin
                    if (HREADY) r_state <= S_REQ;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push && !take_branch) begin
            r_pc_mem[r_wr_ptr]   <= r_data_addr;
            r_inst_mem[r_wr_ptr] <= w_fetched_inst;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_fetch_count <= '0;
            r_flush_count <= '0;
        end else if (take_branch) begin
            r_flush_count <= r_flush_count + 32'd1;
        end else if (w_push) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;
`endif

endmodule

`default_nettype wire
